// File: rtl/three_dee_array_reg.sv
// One-cycle register stage for a set of multidimensional port arrays.
// Every output element is the same-indexed input element sampled at the last rising CLK edge.
module three_dee_array_reg #(
  parameter string PRSIM_NAME = "foo_1",
  parameter int    AW_I       = 2,
  parameter int    AW_J       = 3,
  parameter int    AW_K       = 8,
  parameter int    GW_K       = 2,
  parameter int    BUS_W      = 4
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [AW_I-1:0][AW_J-1:0][AW_K-1:0] A,
  output logic [AW_I-1:0][AW_J-1:0][AW_K-1:0] B,
  input  logic [BUS_W-1:0]                    C,
  output logic [BUS_W-1:0]                    D,
  input  logic                                E [BUS_W],
  output logic                                F [BUS_W],
  input  logic [AW_I-1:0][AW_J-1:0][GW_K-1:0] G,
  output logic [AW_I-1:0][AW_J-1:0][GW_K-1:0] H
);

  // The instance tag only selects an empty named scope for simulator binding.
  if (PRSIM_NAME != "") begin : g_tagged
  end else begin : g_untagged
  end

  // One register per (i, j) slice keeps each element's path independent.
  for (genvar gi = 0; gi < AW_I; gi++) begin : g_i
    for (genvar gj = 0; gj < AW_J; gj++) begin : g_j
      logic [AW_K-1:0] b_reg;
      logic [GW_K-1:0] h_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          b_reg <= '0;
          h_reg <= '0;
        end else begin
          b_reg <= A[gi][gj];
          h_reg <= G[gi][gj];
        end
      end

      assign B[gi][gj] = b_reg;
      assign H[gi][gj] = h_reg;
    end
  end

  for (genvar gi = 0; gi < BUS_W; gi++) begin : g_n
    logic d_reg;
    logic f_reg;

    always_ff @(posedge CLK) begin
      if (RST) begin
        d_reg <= 1'b0;
        f_reg <= 1'b0;
      end else begin
        d_reg <= C[gi];
        f_reg <= E[gi];
      end
    end

    assign D[gi] = d_reg;
    assign F[gi] = f_reg;
  end

endmodule

// File: tb/tb_three_dee_array_reg.sv
// Self-checking bench for three_dee_array_reg: directed element tests plus a
// randomized run against a "output = input sampled at the previous edge" model.
`timescale 1ps/1ps
module tb_three_dee_array_reg;

  localparam int HALF_PERIOD = 50;

  logic                   clk;
  logic                   rst;
  logic [1:0][2:0][7:0]   a;
  logic [1:0][2:0][7:0]   b;
  logic [3:0]             c;
  logic [3:0]             d;
  logic [3:0]             e_vec;
  logic                   e [4];
  logic                   f [4];
  logic [3:0]             f_vec;
  logic [1:0][2:0][1:0]   g;
  logic [1:0][2:0][1:0]   h;

  int total = 0;
  int bad   = 0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_e
    assign e[gi]     = e_vec[gi];
    assign f_vec[gi] = f[gi];
  end

  three_dee_array_reg #(
    .PRSIM_NAME("foo_1"), .AW_I(2), .AW_J(3), .AW_K(8), .GW_K(2), .BUS_W(4)
  ) dut (
    .CLK(clk), .RST(rst),
    .A(a), .B(b),
    .C(c), .D(d),
    .E(e), .F(f),
    .G(g), .H(h)
  );

  // clk_gen: starts low, rising edges at 50, 150, 250, ... ps
  initial begin
    clk = 1'b0;
    forever #(HALF_PERIOD) clk = ~clk;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    a = '1; c = '1; e_vec = '1; g = '1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      total++;
      if (b !== '0 || d !== '0 || f_vec !== '0 || h !== '0) begin
        bad++;
        $display("FAIL reset_edge%0d: B=%h D=%h F=%h H=%h, required all zero", k, b, d, f_vec, h);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (b !== '1 || d !== '1 || f_vec !== '1 || h !== '1) begin
      bad++;
      $display("FAIL reset_release: B=%h D=%h F=%h H=%h, required all ones", b, d, f_vec, h);
    end
    $display("test_reset: done");
  endtask

  // Drives one bit (C[1] or G[1][2][0]) with the reference waveform at absolute
  // offsets from a base where base+50 is a rising edge; other bits are held constant.
  task automatic test_waveform(input bit use_g);
    int ev_t [7] = '{20, 420, 820, 920, 1020, 1120, 1420};
    bit ev_v [7] = '{0, 1, 0, 1, 0, 1, 0};
    time base;
    logic [3:0]           exp_d;
    logic [1:0][2:0][1:0] exp_h;
    bit  v;
    rst = 1'b0;
    c = 4'b1000;
    g = '0;
    g[0][0] = 2'b11;
    g[1][1] = 2'b10;
    @(posedge clk);
    base = $time + 50;
    fork
      begin
        for (int k = 0; k < 7; k++) begin
          #(base + ev_t[k] - $time);
          if (use_g) g[1][2][0] = ev_v[k];
          else       c[1] = ev_v[k];
        end
      end
      begin
        for (int cyc = 0; cyc < 16; cyc++) begin
          #(base + 100 * cyc + 51 - $time);
          v = 1'b0;
          for (int k = 0; k < 7; k++)
            if (ev_t[k] < 100 * cyc + 50) v = ev_v[k];
          total++;
          if (use_g) begin
            exp_h = '0;
            exp_h[0][0] = 2'b11;
            exp_h[1][1] = 2'b10;
            exp_h[1][2][0] = v;
            if (h !== exp_h) begin
              bad++;
              $display("FAIL g_wave t=%0t: H=%h, required %h", $time - base, h, exp_h);
            end
          end else begin
            exp_d = {1'b1, 1'b0, v, 1'b0};
            if (d !== exp_d) begin
              bad++;
              $display("FAIL c_wave t=%0t: D=%b, required %b", $time - base, d, exp_d);
            end
          end
        end
      end
    join
    $display("test_waveform(%s): done", use_g ? "G[1][2][0]" : "C[1]");
  endtask

  task automatic test_vector_slice();
    logic [7:0] vals [3] = '{8'hFF, 8'h00, 8'hA5};
    logic [1:0][2:0][7:0] exp_b;
    a = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      a[1][2] = vals[k];
      @(posedge clk); #1;
      exp_b = '0;
      exp_b[1][2] = vals[k];
      total++;
      if (b !== exp_b) begin
        bad++;
        $display("FAIL vector_slice%0d: B=%h, required %h", k, b, exp_b);
      end
    end
    $display("test_vector_slice: done");
  endtask

  task automatic test_unpacked();
    e_vec = '0;
    @(posedge clk); #1;
    e_vec[2] = 1'b1;
    @(posedge clk); #1;
    total++;
    if (f_vec !== 4'b0100) begin
      bad++;
      $display("FAIL unpacked_e2: F=%b, required 0100", f_vec);
    end
    $display("test_unpacked: done");
  endtask

  // C toggles every cycle, RST pulses for one edge, and some cycles carry a glitch.
  task automatic test_mid_reset();
    logic [3:0] exp_d;
    c = 4'b0101;
    rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      c = ~c;
      rst = (cyc == 4);
      if (cyc == 6 || cyc == 8) begin
        #20 c = ~c;
        #20 c = ~c;
      end
      exp_d = rst ? 4'b0000 : c;
      @(posedge clk); #1;
      total++;
      if (d !== exp_d) begin
        bad++;
        $display("FAIL mid_reset cyc%0d: D=%b, required %b", cyc, d, exp_d);
      end
    end
    rst = 1'b0;
    $display("test_mid_reset: done");
  endtask

  task automatic test_random();
    logic [1:0][2:0][7:0] exp_b;
    logic [3:0]           exp_d;
    logic [3:0]           exp_f;
    logic [1:0][2:0][1:0] exp_h;
    for (int cyc = 0; cyc < 60; cyc++) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 3; j++) begin
          a[i][j] = 8'($urandom_range(0, 255));
          g[i][j] = 2'($urandom_range(0, 3));
        end
      c     = 4'($urandom_range(0, 15));
      e_vec = 4'($urandom_range(0, 15));
      rst   = ($urandom_range(0, 9) == 0);
      exp_b = rst ? '0 : a;
      exp_d = rst ? '0 : c;
      exp_f = rst ? '0 : e_vec;
      exp_h = rst ? '0 : g;
      @(posedge clk); #1;
      total++;
      if (b !== exp_b || d !== exp_d || f_vec !== exp_f || h !== exp_h) begin
        bad++;
        $display("FAIL random cyc%0d rst=%0b: B=%h D=%h F=%h H=%h, required B=%h D=%h F=%h H=%h",
                 cyc, rst, b, d, f_vec, h, exp_b, exp_d, exp_f, exp_h);
      end
    end
    rst = 1'b0;
    $display("test_random: done");
  endtask

  initial begin
    rst = 1'b1;
    a = '0; c = '0; e_vec = '0; g = '0;
    test_reset();
    test_waveform(1'b0);
    test_waveform(1'b1);
    test_vector_slice();
    test_unpacked();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
